// File: rtl/fica_pkg.sv
// Shared constants for the FastICA iteration scheduler: state encoding and default widths.
package fica_pkg;

    localparam int unsigned FICA_DW  = 16;
    localparam int unsigned FICA_ITW = 7;
    localparam int unsigned STATE_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_UPDATE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_SYMM_ARM  = 3'd2;
    localparam logic [STATE_W-1:0] ST_SYMM_WAIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_CONV      = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/fica_stage_timer.sv
// Loadable down-counter with a terminal flag; times the UPDATE stage and the
// optional SYMM_WAIT timeout.
module fica_stage_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/fica_iter_scheduler.sv
// FastICA iteration sequencer: UPDATE -> SYMM_ARM -> SYMM_WAIT -> CONV per iteration,
// ending on convergence, MAX_ITER, or abort.
// Optional macro ICA_SYMM_TIMEOUT_EN bounds SYMM_WAIT to SYMM_TMO cycles and raises fault.
module fica_iter_scheduler
    import fica_pkg::*;
#(
    parameter int unsigned DW         = FICA_DW,
    parameter int unsigned MAX_ITER   = 64,
    parameter int unsigned ITW        = FICA_ITW,
    parameter int unsigned UPD_CYCLES = 4,
    parameter int unsigned SYMM_TMO   = 32
) (
    input  logic          clk_iter,
    input  logic          go_iter,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] tol,
    input  logic          conv_valid,
    input  logic [DW-1:0] conv_delta,
    input  logic          symm_busy,
    output logic          en_upd,
    output logic          go_symm,
    output logic          en_conv,
    output logic [ITW-1:0] iter_cnt,
    output logic          ica_busy,
    output logic          ica_done,
    output logic          converged,
    output logic          fault
);

    localparam int unsigned TMR_MAX = (UPD_CYCLES > SYMM_TMO) ? UPD_CYCLES : SYMM_TMO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] UPD_LOAD = TMR_W'(UPD_CYCLES - 1);
`ifdef ICA_SYMM_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(SYMM_TMO - 1);
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic [ITW-1:0]     iter_q, iter_d;
    logic [DW-1:0]      tol_q, tol_d;
    logic               conv_q, conv_d;
    logic               fault_q, fault_d;
    logic               seen_q, seen_d;
    logic               tmr_load, tmr_dec, tmr_tc_c;
    logic [TMR_W-1:0]   tmr_val;
    logic [ITW-1:0]     iter_inc;

    assign iter_inc = iter_q + ITW'(1);

    // Shared stage timer: UPDATE length, and SYMM_WAIT timeout when enabled.
    fica_stage_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk_iter),
        .rst_n    (go_iter),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .tc_c     (tmr_tc_c)
    );

    // State and run-context registers.
    always_ff @(posedge clk_iter or negedge go_iter) begin
        if (!go_iter) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            tol_q   <= '0;
            conv_q  <= 1'b0;
            fault_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            tol_q   <= tol_d;
            conv_q  <= conv_d;
            fault_q <= fault_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state and register-update logic; abort overrides everything, including start.
    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        tol_d    = tol_q;
        conv_d   = conv_q;
        fault_d  = fault_q;
        seen_d   = seen_q;
        tmr_load = 1'b0;
        tmr_val  = UPD_LOAD;
        tmr_dec  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            iter_d  = '0;
            conv_d  = 1'b0;
            fault_d = 1'b0;
            seen_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_UPDATE;
                        tol_d    = tol;
                        iter_d   = '0;
                        conv_d   = 1'b0;
                        fault_d  = 1'b0;
                        tmr_load = 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (tmr_tc_c) begin
                        state_d = ST_SYMM_ARM;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_SYMM_ARM: begin
                    state_d = ST_SYMM_WAIT;
                    seen_d  = 1'b0;
`ifdef ICA_SYMM_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
`endif
                end
                ST_SYMM_WAIT: begin
                    if (symm_busy) begin
                        seen_d = 1'b1;
                    end
                    if (seen_q && !symm_busy) begin
                        state_d = ST_CONV;
`ifdef ICA_SYMM_TIMEOUT_EN
                    end else if (tmr_tc_c) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        conv_d  = 1'b0;
                    end else begin
                        tmr_dec = 1'b1;
`endif
                    end
                end
                ST_CONV: begin
                    if (conv_valid) begin
                        iter_d = iter_inc;
                        if (conv_delta < tol_q) begin
                            state_d = ST_DONE;
                            conv_d  = 1'b1;
                        end else if (iter_inc == ITW'(MAX_ITER)) begin
                            state_d = ST_DONE;
                            conv_d  = 1'b0;
                        end else begin
                            state_d  = ST_UPDATE;
                            tmr_load = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Stage enables decoded from state; go_symm low holds the symm controller in reset.
    assign en_upd    = (state_q == ST_UPDATE);
    assign go_symm   = (state_q == ST_SYMM_WAIT) || (state_q == ST_CONV);
    assign en_conv   = (state_q == ST_CONV);
    assign ica_busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign ica_done  = (state_q == ST_DONE);
    assign iter_cnt  = iter_q;
    assign converged = conv_q;
`ifdef ICA_SYMM_TIMEOUT_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: doc/fica_iter_scheduler.md
Name: fica_iter_scheduler

Overview:
- Top-level iteration sequencer for one FastICA weight-estimation run.
- Each iteration runs three stages in order: fixed-point update, symmetric orthogonalisation, convergence check.
- Drives go_symm into the symmetric-orthogonalisation controller and watches its symm_busy. Ends on convergence, on reaching MAX_ITER, or on abort.

Parameters:
DW, 16, width of conv_delta and tol (unsigned)
MAX_ITER, 64, iteration limit (1..2^ITW-1)
ITW, 7, width of iter_cnt
UPD_CYCLES, 4, cycles en_upd is held per iteration (>=1)
SYMM_TMO, 32, max cycles in SYMM_WAIT before fault (ICA_SYMM_TIMEOUT_EN only)

Ports:
clk_iter  in  1  clock; all state on posedge
go_iter  in  1  asynchronous active-low reset
start  in  1  one-cycle run request; honoured only in IDLE or DONE
abort  in  1  synchronous abort, priority over all transitions
tol  in  DW  convergence tolerance, sampled on accepted start
conv_valid  in  1  conv_delta valid
conv_delta  in  DW  max |w_new - w_old| from datapath
symm_busy  in  1  busy from symm-orth controller
en_upd  out  1  update datapath enable
go_symm  out  1  run/reset (active-low) to symm-orth controller
en_conv  out  1  convergence-unit enable
iter_cnt  out  ITW  completed iterations
ica_busy  out  1  high outside IDLE/DONE
ica_done  out  1  high in DONE
converged  out  1  valid with ica_done
fault  out  1  symm timeout flag (0 if macro off)

Behaviour:
- Reset (go_iter=0): state=IDLE, iter_cnt=0, tol_q=0, sub-counter=0. All outputs 0, including go_symm (holds symm controller in reset).
- States:
  - IDLE: start -> UPDATE; tol_q<=tol; iter_cnt<=0; converged<=0; fault<=0.
  - UPDATE: en_upd=1 for exactly UPD_CYCLES cycles (cnt 0..UPD_CYCLES-1), then -> SYMM_ARM.
  - SYMM_ARM: go_symm=0 for exactly one cycle, re-initialising the symm controller; -> SYMM_WAIT; cnt<=0.
  - SYMM_WAIT: go_symm=1.
    - Symm controller raises symm_busy in the same cycle and drops it after 6 cycles.
    - A seen_busy flag is set on the first symm_busy=1.
    - seen_busy && symm_busy==0 -> CONV.
    - symm_busy never rising keeps the block in SYMM_WAIT; bounded only with the macro.
  - CONV: go_symm=1 (symm held in PAUSE), en_conv=1; wait for conv_valid.
    - On conv_valid: iter_cnt<=iter_cnt+1.
    - conv_delta < tol_q (strict, unsigned): converged<=1, -> DONE.
    - else iter_cnt+1 == MAX_ITER: converged<=0, -> DONE.
    - else -> UPDATE.
  - DONE: ica_done=1, go_symm=0, iter_cnt/converged/fault held; start -> UPDATE (same actions as from IDLE).
- abort in any state except IDLE: -> IDLE next edge, all enables 0; iter_cnt and converged cleared. abort with start in the same cycle: abort wins.
- start outside IDLE/DONE: ignored.
- conv_valid outside CONV: ignored.
- iter_cnt never wraps: MAX_ITER bounds it below 2^ITW.
- Outputs decoded combinationally from state, except iter_cnt/converged/fault (registered).
- Async reset mid-run: immediate return to reset values; go_symm=0 also resets the symm controller.

Optional Feature:
- Macro ICA_SYMM_TIMEOUT_EN.
- With it: cnt counts SYMM_WAIT cycles; cnt==SYMM_TMO-1 without completion -> DONE with fault=1, converged=0, iter_cnt unchanged.
- Without it: fault tied 0; SYMM_WAIT waits indefinitely; SYMM_TMO unused.

Decomposition:
- Package fica_pkg: state enum (IDLE, UPDATE, SYMM_ARM, SYMM_WAIT, CONV, DONE), state width constant, default DW/ITW.
- One natural sub-module, fica_stage_timer: loadable down-counter with terminal flag. It is shared by UPDATE length and the SYMM_WAIT timeout.
- Convergence compare stays inline.

Test Plan:
- Reset then start, tol=0x0100, conv_delta=0x0080 on first CONV: en_upd high 4 cycles, go_symm low 1 cycle then high ~7 cycles, then ica_done=1, converged=1, iter_cnt=1.
- tol=0x0010, conv_delta always 0x0200, MAX_ITER=64: exactly 64 UPDATE/SYMM/CONV rounds; ica_done=1, converged=0, iter_cnt=64.
- Abort asserted during SYMM_WAIT of iteration 3: next cycle IDLE, all enables and go_symm 0, iter_cnt=0.
- Start pulses during UPDATE and CONV are ignored. Start in DONE launches a new run with iter_cnt reset to 0 and the new tol sampled.
- With ICA_SYMM_TIMEOUT_EN, symm_busy stuck 0: after 32 SYMM_WAIT cycles DONE, fault=1, converged=0. Without the macro, the block is still in SYMM_WAIT after 1000 cycles.
- go_iter pulsed low mid-CONV: all outputs 0 asynchronously, state IDLE. conv_valid arriving afterwards is ignored.
